hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard and stall sequencer for the 3-stage core: l1 fetch, l2 decode/execute, l3 memory/writeback.
- Generates hold, bubble and flush controls for each stage.
- Starts and waits on the multi-cycle mul/div unit.
- Produces the operand-forward selects that steer the l3 writeback value onto alu_a/alu_b in l2.
- Keeps a saturating stall-cycle counter for performance monitoring.

Parameters:
- FLUSH_CYCLES, 2, cycles flush_l1 stays asserted per accepted redirect (legal 1..8; covers imem latency).
- CNT_W, 16, width of perf_stall_cnt.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- l2_valid  in  1  l2 holds a real instruction
- l2_rs1  in  5  l2 source register 1
- l2_rs2  in  5  l2 source register 2
- l2_rs1_used  in  1  instruction in l2 reads rs1
- l2_rs2_used  in  1  instruction in l2 reads rs2
- l2_is_mdiv  in  1  l2 instruction needs the multi-cycle mul/div unit
- redirect_l2  in  1  branch/jump resolved taken in l2
- l3_valid  in  1  l3 holds a real instruction
- l3_rd  in  5  l3 destination register
- l3_wen  in  1  l3 writes rd
- l3_is_load  in  1  l3 instruction is a load
- dmem_rvalid  in  1  load data for l3 available this cycle
- mdiv_done  in  1  mul/div result valid this cycle
- mdiv_start  out  1  registered one-cycle start pulse to mul/div
- stall_l1  out  1  hold PC/l1 register
- stall_l2  out  1  hold l2 register
- stall_l3  out  1  hold l3 register
- bubble_l3  out  1  load a NOP into l3 at next edge
- flush_l1  out  1  squash instruction leaving l1
- fwd_a  out  1  select wval_l3 for alu_a
- fwd_b  out  1  select wval_l3 for alu_b
- perf_stall_cnt  out  CNT_W  saturating count of stall_l2 cycles

Behaviour:
- States: RUN, MDIV_WAIT, FLUSH. Reset -> RUN; mdiv_start=0, flush counter=0, perf_stall_cnt=0. All combinational outputs follow from reset state plus inputs.
- mem_wait = l3_valid & l3_is_load & !dmem_rvalid. Evaluated in every state; highest priority.
- stall_l3 = mem_wait.
- mdiv_hold = l2_valid & l2_is_mdiv & !(state==MDIV_WAIT & mdiv_done).
- stall_l2 = stall_l1 = mem_wait | mdiv_hold.
- bubble_l3 = stall_l2 & !stall_l3. Never both bubble_l3 and stall_l3.
- fwd_a = l3_valid & l3_wen & (l3_rd!=0) & l2_rs1_used & (l2_rs1==l3_rd). fwd_b is the same using rs2.
- Forward selects are combinational, zero latency. An x0 source never forwards.
- RUN -> MDIV_WAIT: when l2_valid & l2_is_mdiv & !mem_wait. mdiv_start is registered high for exactly the first MDIV_WAIT cycle.
- If mem_wait is high, the mdiv start is deferred until mem_wait drops. No start pulse is issued while in FLUSH.
- MDIV_WAIT -> RUN: on the cycle mdiv_done=1. In that cycle mdiv_hold=0, so l2 advances unless mem_wait is high.
- If mem_wait is high in the mdiv_done cycle, stay in MDIV_WAIT with a done_seen flag set. mdiv_hold is then forced low, and exit happens on the first cycle with !mem_wait.
- Redirect accepted = l2_valid & redirect_l2 & !stall_l2 (RUN state only). Accept asserts flush_l1 in that same cycle.
- If FLUSH_CYCLES>1 on accept: go to FLUSH and load the counter with FLUSH_CYCLES-1. flush_l1 stays high in FLUSH; the counter decrements every cycle, including cycles where stall_l3 is high. At 0 -> RUN.
- A redirect while stall_l2 is high is not accepted. The l2 instruction is held and re-presents it, so no latch is required.
- A redirect and an mdiv op in the same l2 instruction is illegal; the mdiv path wins.
- perf_stall_cnt increments by 1 on each cycle with stall_l2=1 and saturates at 2^CNT_W-1.
- Reset asserted mid-operation (any state) returns to RUN next edge. The in-flight mul/div is abandoned, and mdiv_done is ignored until a new start.

Test Plan:
- l3: valid, wen, rd=5; l2: rs1=5, rs2=0, both used -> fwd_a=1, fwd_b=0. With rd=0, rs1=0 -> fwd_a=0.
- Load in l3 with dmem_rvalid low for 3 cycles, then high -> stall_l1/l2/l3=1 for exactly 3 cycles, bubble_l3=0, perf_stall_cnt=3.
- l2_is_mdiv, mdiv_done 4 cycles after start -> one mdiv_start pulse; stall_l2=1 and bubble_l3=1 for 5 cycles (start cycle + 4); l2 advances on the done cycle; state RUN afterwards.
- redirect_l2 in RUN with FLUSH_CYCLES=2 -> flush_l1=1 for 2 consecutive cycles, then 0. Repeat with stall_l2 high -> no flush until the stall clears.
- mdiv_done coincides with mem_wait -> l2 stays held until dmem_rvalid, exactly one start pulse, no second start.
- CNT_W=4, 20 stall cycles -> perf_stall_cnt=15. rst mid-MDIV_WAIT -> all outputs 0 and state RUN the next cycle.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard and stall sequencer for the 3-stage core.
// Drives hold/bubble/flush, mul/div start and forward selects.
module hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             l2_valid,
  input  logic [4:0]       l2_rs1,
  input  logic [4:0]       l2_rs2,
  input  logic             l2_rs1_used,
  input  logic             l2_rs2_used,
  input  logic             l2_is_mdiv,
  input  logic             redirect_l2,
  input  logic             l3_valid,
  input  logic [4:0]       l3_rd,
  input  logic             l3_wen,
  input  logic             l3_is_load,
  input  logic             dmem_rvalid,
  input  logic             mdiv_done,
  output logic             mdiv_start,
  output logic             stall_l1,
  output logic             stall_l2,
  output logic             stall_l3,
  output logic             bubble_l3,
  output logic             flush_l1,
  output logic             fwd_a,
  output logic             fwd_b,
  output logic [CNT_W-1:0] perf_stall_cnt
);

  typedef enum logic [1:0] {
    RUN,
    MDIV_WAIT,
    FLUSH
  } state_t;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE =
    {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [3:0]       fcnt_q, fcnt_d;
  logic             done_seen_q, done_seen_d;
  logic             mdiv_start_q, mdiv_start_d;
  logic [CNT_W-1:0] perf_q;

  logic mem_wait;
  logic done_eff;
  logic mdiv_hold;
  logic stall;
  logic accept;
  logic l3_fwd_ok;

  assign mem_wait  = l3_valid & l3_is_load & ~dmem_rvalid;
  // A done seen under mem_wait stays latched until memory releases.
  assign done_eff  = (state_q == MDIV_WAIT) &
                     (mdiv_done | done_seen_q);
  assign mdiv_hold = l2_valid & l2_is_mdiv & ~done_eff;
  assign stall     = mem_wait | mdiv_hold;
  assign accept    = (state_q == RUN) & l2_valid &
                     redirect_l2 & ~stall;

  assign l3_fwd_ok = l3_valid & l3_wen & (l3_rd != 5'd0);
  assign fwd_a     = l3_fwd_ok & l2_rs1_used & (l2_rs1 == l3_rd);
  assign fwd_b     = l3_fwd_ok & l2_rs2_used & (l2_rs2 == l3_rd);

  assign stall_l3       = mem_wait;
  assign stall_l2       = stall;
  assign stall_l1       = stall;
  assign bubble_l3      = stall & ~mem_wait;
  assign flush_l1       = accept | (state_q == FLUSH);
  assign mdiv_start     = mdiv_start_q;
  assign perf_stall_cnt = perf_q;

  // Next-state logic for the sequencer FSM.
  always_comb begin
    state_d      = state_q;
    fcnt_d       = fcnt_q;
    done_seen_d  = done_seen_q;
    mdiv_start_d = 1'b0;
    unique case (state_q)
      RUN: begin
        if (l2_valid & l2_is_mdiv & ~mem_wait) begin
          state_d      = MDIV_WAIT;
          mdiv_start_d = 1'b1;
          done_seen_d  = 1'b0;
        end else if (accept && (FLUSH_CYCLES > 1)) begin
          state_d = FLUSH;
          fcnt_d  = FLUSH_LOAD;
        end
      end
      MDIV_WAIT: begin
        if (mdiv_done | done_seen_q) begin
          if (mem_wait) begin
            done_seen_d = 1'b1;
          end else begin
            state_d     = RUN;
            done_seen_d = 1'b0;
          end
        end
      end
      FLUSH: begin
        fcnt_d = fcnt_q - 4'd1;
        if (fcnt_q <= 4'd1) begin
          state_d = RUN;
          fcnt_d  = 4'd0;
        end
      end
      default: begin
        state_d = RUN;
        fcnt_d  = 4'd0;
      end
    endcase
  end

  // State, start pulse and flush counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      fcnt_q       <= 4'd0;
      done_seen_q  <= 1'b0;
      mdiv_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fcnt_q       <= fcnt_d;
      done_seen_q  <= done_seen_d;
      mdiv_start_q <= mdiv_start_d;
    end
  end

  // Saturating count of l2 stall cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_q <= '0;
    end else if (stall && (perf_q != CNT_MAX)) begin
      perf_q <= perf_q + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl.
// Driver queues expected outputs; monitor checks each cycle.
module tb_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic       l2_valid;
  logic [4:0] l2_rs1;
  logic [4:0] l2_rs2;
  logic       l2_rs1_used;
  logic       l2_rs2_used;
  logic       l2_is_mdiv;
  logic       redirect_l2;
  logic       l3_valid;
  logic [4:0] l3_rd;
  logic       l3_wen;
  logic       l3_is_load;
  logic       dmem_rvalid;
  logic       mdiv_done;
  logic       mdiv_start;
  logic       stall_l1;
  logic       stall_l2;
  logic       stall_l3;
  logic       bubble_l3;
  logic       flush_l1;
  logic       fwd_a;
  logic       fwd_b;
  logic [3:0] perf_stall_cnt;

  hazard_ctrl #(
    .FLUSH_CYCLES(2),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .l2_valid(l2_valid),
    .l2_rs1(l2_rs1),
    .l2_rs2(l2_rs2),
    .l2_rs1_used(l2_rs1_used),
    .l2_rs2_used(l2_rs2_used),
    .l2_is_mdiv(l2_is_mdiv),
    .redirect_l2(redirect_l2),
    .l3_valid(l3_valid),
    .l3_rd(l3_rd),
    .l3_wen(l3_wen),
    .l3_is_load(l3_is_load),
    .dmem_rvalid(dmem_rvalid),
    .mdiv_done(mdiv_done),
    .mdiv_start(mdiv_start),
    .stall_l1(stall_l1),
    .stall_l2(stall_l2),
    .stall_l3(stall_l3),
    .bubble_l3(bubble_l3),
    .flush_l1(flush_l1),
    .fwd_a(fwd_a),
    .fwd_b(fwd_b),
    .perf_stall_cnt(perf_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  string       q_nm[$];
  logic [11:0] q_exp[$];
  int          checks = 0;
  int          passes = 0;
  logic [11:0] m_exp;
  logic [11:0] m_got;
  string       m_nm;

  // {ms, s1, s2, s3, bubble, flush, fa, fb, cnt}
  function automatic logic [11:0] ex(
    input logic ms, input logic s, input logic s3,
    input logic b, input logic fl, input logic fa,
    input logic fb, input int cnt);
    logic [3:0] c;
    c  = 4'(cnt);
    ex = {ms, s, s, s3, b, fl, fa, fb, c};
  endfunction

  always @(negedge clk) begin
    if (q_exp.size() > 0) begin
      m_exp = q_exp.pop_front();
      m_nm  = q_nm.pop_front();
      m_got = {mdiv_start, stall_l1, stall_l2, stall_l3,
               bubble_l3, flush_l1, fwd_a, fwd_b,
               perf_stall_cnt};
      checks++;
      if (m_got === m_exp) passes++;
      else $display("FAIL %s got=%b exp=%b",
                    m_nm, m_got, m_exp);
    end
  end

  task automatic idle();
    l2_valid    = 1'b0;
    l2_rs1      = 5'd0;
    l2_rs2      = 5'd0;
    l2_rs1_used = 1'b0;
    l2_rs2_used = 1'b0;
    l2_is_mdiv  = 1'b0;
    redirect_l2 = 1'b0;
    l3_valid    = 1'b0;
    l3_rd       = 5'd0;
    l3_wen      = 1'b0;
    l3_is_load  = 1'b0;
    dmem_rvalid = 1'b0;
    mdiv_done   = 1'b0;
  endtask

  task automatic step(input string nm, input logic [11:0] e);
    q_nm.push_back(nm);
    q_exp.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic mem_block();
    l3_valid    = 1'b1;
    l3_is_load  = 1'b1;
    dmem_rvalid = 1'b0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    step("reset", ex(0, 0, 0, 0, 0, 0, 0, 0));

    l3_valid = 1; l3_wen = 1; l3_rd = 5;
    l2_valid = 1; l2_rs1 = 5; l2_rs2 = 0;
    l2_rs1_used = 1; l2_rs2_used = 1;
    step("fwd_a", ex(0, 0, 0, 0, 0, 1, 0, 0));
    l3_rd = 0; l2_rs1 = 0;
    step("fwd_x0", ex(0, 0, 0, 0, 0, 0, 0, 0));
    l3_rd = 5; l2_rs1 = 3; l2_rs2 = 5;
    step("fwd_b", ex(0, 0, 0, 0, 0, 0, 1, 0));
    l2_rs2_used = 0;
    step("fwd_unused", ex(0, 0, 0, 0, 0, 0, 0, 0));
    l2_rs1 = 5; l2_rs2_used = 1;
    step("fwd_ab", ex(0, 0, 0, 0, 0, 1, 1, 0));
    l3_wen = 0;
    step("fwd_nowen", ex(0, 0, 0, 0, 0, 0, 0, 0));

    do_reset();
    mem_block();
    l3_wen = 1; l3_rd = 7;
    l2_valid = 1; l2_rs1 = 1; l2_rs2 = 2;
    l2_rs1_used = 1; l2_rs2_used = 1;
    for (int i = 0; i < 3; i++)
      step("ld_stall", ex(0, 1, 1, 0, 0, 0, 0, i));
    dmem_rvalid = 1;
    step("ld_done", ex(0, 0, 0, 0, 0, 0, 0, 3));
    idle();
    step("ld_cnt", ex(0, 0, 0, 0, 0, 0, 0, 3));

    do_reset();
    l2_valid = 1; l2_is_mdiv = 1;
    step("md_run", ex(0, 1, 0, 1, 0, 0, 0, 0));
    step("md_start", ex(1, 1, 0, 1, 0, 0, 0, 1));
    for (int i = 2; i < 5; i++)
      step("md_wait", ex(0, 1, 0, 1, 0, 0, 0, i));
    mdiv_done = 1;
    step("md_done", ex(0, 0, 0, 0, 0, 0, 0, 5));
    mdiv_done = 0; l2_is_mdiv = 0; redirect_l2 = 1;
    step("md_redir", ex(0, 0, 0, 0, 1, 0, 0, 5));
    idle();
    step("flush2", ex(0, 0, 0, 0, 1, 0, 0, 5));
    step("flush_end", ex(0, 0, 0, 0, 0, 0, 0, 5));

    do_reset();
    l2_valid = 1; redirect_l2 = 1;
    mem_block();
    for (int i = 0; i < 2; i++)
      step("rd_stall", ex(0, 1, 1, 0, 0, 0, 0, i));
    dmem_rvalid = 1;
    step("rd_accept", ex(0, 0, 0, 0, 1, 0, 0, 2));
    idle();
    mem_block();
    step("fl_memw", ex(0, 1, 1, 0, 1, 0, 0, 2));
    idle();
    step("fl_done", ex(0, 0, 0, 0, 0, 0, 0, 3));

    do_reset();
    l2_valid = 1; l2_is_mdiv = 1;
    step("mm_run", ex(0, 1, 0, 1, 0, 0, 0, 0));
    step("mm_start", ex(1, 1, 0, 1, 0, 0, 0, 1));
    mdiv_done = 1;
    mem_block();
    step("mm_done_memw", ex(0, 1, 1, 0, 0, 0, 0, 2));
    mdiv_done = 0;
    step("mm_hold", ex(0, 1, 1, 0, 0, 0, 0, 3));
    dmem_rvalid = 1;
    step("mm_release", ex(0, 0, 0, 0, 0, 0, 0, 4));
    idle();
    step("mm_nostart", ex(0, 0, 0, 0, 0, 0, 0, 4));
    step("mm_nostart2", ex(0, 0, 0, 0, 0, 0, 0, 4));

    do_reset();
    l2_valid = 1; l2_is_mdiv = 1;
    mem_block();
    step("df_memw", ex(0, 1, 1, 0, 0, 0, 0, 0));
    dmem_rvalid = 1;
    step("df_go", ex(0, 1, 0, 1, 0, 0, 0, 1));
    step("df_start", ex(1, 1, 0, 1, 0, 0, 0, 2));
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    idle();
    step("rst_mw", ex(0, 0, 0, 0, 0, 0, 0, 0));
    l2_valid = 1; l2_is_mdiv = 1; mdiv_done = 1;
    step("rst_ign_done", ex(0, 1, 0, 1, 0, 0, 0, 0));

    do_reset();
    mem_block();
    for (int i = 0; i < 20; i++)
      step("sat", ex(0, 1, 1, 0, 0, 0, 0,
                     (i > 15) ? 15 : i));
    idle();
    step("sat_hold", ex(0, 0, 0, 0, 0, 0, 0, 15));

    for (int i = 0; i < 10; i++) begin
      if (q_exp.size() != 0) @(negedge clk);
    end
    #1;
    if (q_exp.size() != 0) begin
      checks++;
      $display("FAIL drain got=%0d exp=0", q_exp.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
